rs_bm_arb: RTL and testbench

- Shares one pipelined Berlekamp-Massey instance (rs_bm) between CH_NUM syndrome producers, one per RS decoder lane.
- Accepts syndrome vectors through round-robin valid/ready arbitration and issues at most one per cycle to the BM.
- Carries each issue's channel tag through a delay line matched to the BM latency.
- Buffers returned error locators in an output FIFO. Credit-based admission guarantees the FIFO never overflows, because the BM has no backpressure.

---
 rtl/rs_bm_arb_pkg.sv | 30 +++
 rtl/rs_bm_tag_fifo.sv | 56 +++++
 rtl/rs_bm_arb.sv | 117 +++++++++++
 tb/tb_rs_bm_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_bm_arb_pkg.sv
// Shared types for the BM arbiter: syndrome/locator layouts and the round-robin picker.
// Pure declarations; no latency or backpressure of its own.
package rs_bm_arb_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int ROOTS_NUM  = 4;
  localparam int RR_MAX     = 32;

  typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] syndrome_t;
  typedef logic [ROOTS_NUM:0][SYMB_WIDTH-1:0]   poly_t;

  // One-hot grant of the first set request at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req, input int ptr,
                                                input int n);
    logic [RR_MAX-1:0]         gnt;
    logic                      found;
    logic [$clog2(RR_MAX)-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = $clog2(RR_MAX)'((ptr + i) % n);
      if (i < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rs_bm_tag_fifo.sv
// First-word-fall-through FIFO with full/empty/count; push to empty shows at the head next cycle.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module rs_bm_tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full    = (count == CNW'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    pop_dat = mem[rd_ptr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/rs_bm_arb.sv
// Round-robin share of one BM pipeline across CH_NUM lanes; accept T -> err_loc_vld at T+2+BM_LAT.
// The BM cannot stall, so admission is credit-limited to OUT_DEPTH results in flight or buffered.
module rs_bm_arb
  import rs_bm_arb_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int BM_LAT    = ROOTS_NUM,
  parameter int OUT_DEPTH = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  syndrome_t [CH_NUM-1:0]      syn_in,
  input  logic [CH_NUM-1:0]           syn_vld,
  output logic [CH_NUM-1:0]           syn_rdy,
  output syndrome_t                   bm_syndrome,
  output logic                        bm_syndrome_vld,
  input  poly_t                       bm_error_locator,
  input  logic                        bm_error_locator_vld,
  output poly_t                       err_loc,
  output logic [$clog2(CH_NUM)-1:0]   err_loc_ch,
  output logic                        err_loc_vld,
  input  logic                        err_loc_rdy,
  output logic [1:0]                  status_err
);
  localparam int CH_W = $clog2(CH_NUM);
  localparam int CW   = $clog2(OUT_DEPTH+1);
  localparam int FW   = $bits(poly_t) + CH_W;

  logic [RR_MAX-1:0]            grant_wide;
  logic [CH_NUM-1:0]            grant;
  logic [CH_W-1:0]              rr_ptr, grant_idx, issue_ch;
  logic [CW-1:0]                credit_cnt, fifo_count;
  logic                         run, issue_ok, issue, pop, push, orphan, overflow;
  logic                         fifo_full, fifo_empty;
  logic [BM_LAT-1:0]            tag_vld;
  logic [BM_LAT-1:0][CH_W-1:0]  tag_ch;
  logic [FW-1:0]                fifo_head;

  always_comb begin
    grant_wide = rr_pick(RR_MAX'(syn_vld), int'(rr_ptr), CH_NUM);
    grant      = grant_wide[CH_NUM-1:0];
    grant_idx  = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (grant_wide[i]) grant_idx = CH_W'(i);
    end
    issue_ok = run & (credit_cnt < CW'(OUT_DEPTH));
    syn_rdy  = grant & {CH_NUM{issue_ok}};
    issue    = issue_ok & (|syn_vld);
    pop      = err_loc_vld & err_loc_rdy;
    push     = bm_error_locator_vld & tag_vld[BM_LAT-1];
    orphan   = bm_error_locator_vld & ~tag_vld[BM_LAT-1];
    overflow = push & fifo_full & ~pop;
  end

  // run keeps syn_rdy low while reset is asserted and for the first cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run             <= 1'b0;
      rr_ptr          <= '0;
      bm_syndrome     <= '0;
      bm_syndrome_vld <= 1'b0;
      issue_ch        <= '0;
      credit_cnt      <= '0;
      status_err      <= '0;
    end else begin
      run             <= 1'b1;
      bm_syndrome_vld <= issue;
      if (issue) begin
        bm_syndrome <= syn_in[grant_idx];
        issue_ch    <= grant_idx;
        rr_ptr      <= (grant_idx == CH_W'(CH_NUM-1)) ? '0 : grant_idx + CH_W'(1);
      end
      case ({issue, pop})
        2'b10:   credit_cnt <= credit_cnt + CW'(1);
        2'b01:   credit_cnt <= credit_cnt - CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase
      status_err <= status_err | {overflow, orphan};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_vld <= '0;
      tag_ch  <= '0;
    end else begin
      tag_vld[0] <= bm_syndrome_vld;
      tag_ch[0]  <= issue_ch;
      for (int i = 1; i < BM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_ch[i]  <= tag_ch[i-1];
      end
    end
  end

  rs_bm_tag_fifo #(
    .W     (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (push),
    .push_dat ({bm_error_locator, tag_ch[BM_LAT-1]}),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign {err_loc, err_loc_ch} = fifo_head;
  assign err_loc_vld           = ~fifo_empty;

  credit_covers_fifo: assert property (@(posedge aclk) disable iff (!aresetn)
    fifo_count <= credit_cnt);

endmodule

// File: tb/tb_rs_bm_arb.sv
// Directed bench for rs_bm_arb around a fixed-latency BM stand-in; expected locators are queued
// at accept time and checked in order by an independent output monitor.
module tb_rs_bm_arb;
  import rs_bm_arb_pkg::*;

  localparam int CH_NUM    = 4;
  localparam int BM_LAT    = ROOTS_NUM;
  localparam int OUT_DEPTH = 4;

  typedef struct packed {
    logic [1:0] ch;
    poly_t      loc;
  } exp_t;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  syndrome_t [CH_NUM-1:0] syn_in;
  logic [CH_NUM-1:0]      syn_vld, syn_rdy;
  syndrome_t              bm_syndrome;
  logic                   bm_syndrome_vld;
  poly_t                  bm_error_locator;
  logic                   bm_error_locator_vld;
  poly_t                  err_loc;
  logic [1:0]             err_loc_ch;
  logic                   err_loc_vld, err_loc_rdy;
  logic [1:0]             status_err;
  logic                   inj;

  logic [BM_LAT-1:0]      bm_pipe_vld = '0;
  poly_t                  bm_pipe_loc [BM_LAT];
  exp_t                   exp_q [$];
  int                     n_vec = 0;
  int                     n_bad = 0;

  always #5 aclk = ~aclk;

  rs_bm_arb #(
    .CH_NUM    (CH_NUM),
    .BM_LAT    (BM_LAT),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .syn_in               (syn_in),
    .syn_vld              (syn_vld),
    .syn_rdy              (syn_rdy),
    .bm_syndrome          (bm_syndrome),
    .bm_syndrome_vld      (bm_syndrome_vld),
    .bm_error_locator     (bm_error_locator),
    .bm_error_locator_vld (bm_error_locator_vld),
    .err_loc              (err_loc),
    .err_loc_ch           (err_loc_ch),
    .err_loc_vld          (err_loc_vld),
    .err_loc_rdy          (err_loc_rdy),
    .status_err           (status_err)
  );

  // Reference locator used by the BM stand-in; any injective-enough mapping exposes routing slips.
  function automatic poly_t ref_loc(input syndrome_t s);
    poly_t p;
    p[0] = 8'h01;
    for (int j = 1; j <= ROOTS_NUM; j++)
      p[j] = s[j-1] ^ {s[ROOTS_NUM-j][6:0], s[ROOTS_NUM-j][7]} ^ 8'(j);
    return p;
  endfunction

  // BM stand-in: fixed BM_LAT pipeline, not reset by aresetn, no backpressure.
  always @(posedge aclk) begin
    bm_pipe_vld[0] <= bm_syndrome_vld;
    bm_pipe_loc[0] <= ref_loc(bm_syndrome);
    for (int i = 1; i < BM_LAT; i++) begin
      bm_pipe_vld[i] <= bm_pipe_vld[i-1];
      bm_pipe_loc[i] <= bm_pipe_loc[i-1];
    end
  end
  assign bm_error_locator_vld = bm_pipe_vld[BM_LAT-1] | inj;
  assign bm_error_locator     = bm_pipe_loc[BM_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive after the edge, sample at the falling edge, queue expectations for accepts.
  task automatic drive(input logic [CH_NUM-1:0] vld, input logic rdy, input logic inj_v,
                       output logic [CH_NUM-1:0] got);
    @(posedge aclk);
    #1;
    syn_vld     = vld;
    err_loc_rdy = rdy;
    inj         = inj_v;
    for (int i = 0; i < CH_NUM; i++) syn_in[i] = $urandom;
    @(negedge aclk);
    got = syn_rdy;
    for (int i = 0; i < CH_NUM; i++)
      if (syn_rdy[i]) exp_q.push_back('{ch: 2'(i), loc: ref_loc(syn_in[i])});
  endtask

  task automatic pulse_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    syn_vld = '0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && err_loc_vld && err_loc_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL out_unexpected: got ch %0d loc %0h, expected no output", err_loc_ch, err_loc);
        end else begin
          e = exp_q.pop_front();
          check("out_ch", 64'(err_loc_ch), 64'(e.ch));
          check("out_loc", 64'(err_loc), 64'(e.loc));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_bad %0d", n_bad);
    $fatal(1);
  end

  logic [CH_NUM-1:0] t2_rdy [14] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0,
                                     4'h8, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0};
  logic [CH_NUM-1:0] t3_rdy [10] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin : stim
    logic [CH_NUM-1:0] g;
    syndrome_t         s2;
    int                first;
    syn_vld     = 4'hF;
    syn_in      = '0;
    err_loc_rdy = 1'b0;
    inj         = 1'b0;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    check("rst_syn_rdy", 64'(syn_rdy), 64'h0);
    check("rst_bm_vld", 64'(bm_syndrome_vld), 64'h0);
    check("rst_bm_syn", 64'(bm_syndrome), 64'h0);
    check("rst_err_vld", 64'(err_loc_vld), 64'h0);
    check("rst_status", 64'(status_err), 64'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    syn_vld = '0;
    repeat (2) drive('0, 1'b1, 1'b0, g);

    // Single request on channel 2, latency and one-cycle issue pulse.
    drive(4'b0100, 1'b1, 1'b0, g);
    s2 = syn_in[2];
    check("t1_rdy", 64'(g), 64'h4);
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      drive('0, 1'b1, 1'b0, g);
      if (n == 1) begin
        check("t1_bm_vld", 64'(bm_syndrome_vld), 64'h1);
        check("t1_bm_syn", 64'(bm_syndrome), 64'(s2));
      end
      if (n == 2) check("t1_bm_pulse", 64'(bm_syndrome_vld), 64'h0);
      if (first < 0 && err_loc_vld) first = n;
    end
    check("t1_latency", 64'(first), 64'(2 + BM_LAT));

    // All channels valid, consumer always ready: round robin from rr_ptr=3, credit-paced.
    for (int k = 0; k < 14; k++) begin
      drive(4'hF, 1'b1, 1'b0, g);
      check($sformatf("t2_rdy[%0d]", k), 64'(g), 64'(t2_rdy[k]));
    end
    repeat (12) drive('0, 1'b1, 1'b0, g);
    check("t2_drained", 64'(exp_q.size()), 64'h0);

    // Consumer stalled: exactly OUT_DEPTH issues, then one pop admits exactly one more.
    for (int k = 0; k < 10; k++) begin
      drive(4'hF, 1'b0, 1'b0, g);
      check($sformatf("t3_rdy[%0d]", k), 64'(g), 64'(t3_rdy[k]));
    end
    check("t3_fifo_vld", 64'(err_loc_vld), 64'h1);
    drive(4'hF, 1'b1, 1'b0, g);
    check("t3_rdy_at_pop", 64'(g), 64'h0);
    drive(4'hF, 1'b0, 1'b0, g);
    check("t3_rdy_after_pop", 64'(g), 64'h8);
    repeat (2) begin
      drive(4'hF, 1'b0, 1'b0, g);
      check("t3_rdy_refull", 64'(g), 64'h0);
    end
    check("t3_status", 64'(status_err), 64'h0);

    // Steady state from a full FIFO with continuous pops; scoreboard catches any loss.
    repeat (20) drive(4'hF, 1'b1, 1'b0, g);
    repeat (15) drive('0, 1'b1, 1'b0, g);
    check("t4_drained", 64'(exp_q.size()), 64'h0);
    check("t4_status", 64'(status_err), 64'h0);

    // Orphan BM output with nothing in flight.
    drive('0, 1'b1, 1'b1, g);
    drive('0, 1'b1, 1'b0, g);
    check("t5_orphan", 64'(status_err), 64'h1);
    check("t5_no_push", 64'(err_loc_vld), 64'h0);
    repeat (5) drive('0, 1'b1, 1'b0, g);
    check("t5_sticky", 64'(status_err), 64'h1);
    pulse_reset();
    check("t5_rst_clear", 64'(status_err), 64'h0);

    // Reset with three issues in flight; late BM outputs become orphans.
    drive('0, 1'b1, 1'b0, g);
    drive(4'b0111, 1'b1, 1'b0, g);
    check("t6_rdy0", 64'(g), 64'h1);
    drive(4'b0111, 1'b1, 1'b0, g);
    check("t6_rdy1", 64'(g), 64'h2);
    drive(4'b0111, 1'b1, 1'b0, g);
    check("t6_rdy2", 64'(g), 64'h4);
    pulse_reset();
    check("t6_bm_vld", 64'(bm_syndrome_vld), 64'h0);
    check("t6_err_vld", 64'(err_loc_vld), 64'h0);
    repeat (6) drive('0, 1'b1, 1'b0, g);
    check("t6_late_orphan", 64'(status_err), 64'h1);
    check("t6_no_late_push", 64'(err_loc_vld), 64'h0);
    drive(4'hF, 1'b1, 1'b0, g);
    check("t6_rr_ptr_reset", 64'(g), 64'h1);
    repeat (12) drive('0, 1'b1, 1'b0, g);
    check("t6_drained", 64'(exp_q.size()), 64'h0);
    check("t6_status_sticky", 64'(status_err), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
